baggage_drop_seq: RTL and testbench

//  Sequential, parametrised baggage-drop controller for N height sensors.
//  On start: snapshot sensors/t_lim/drop_en; average the non-zero readings (iterative divide).

---
 rtl/baggage_drop_seq.sv | 186 ++++++++++++++++++
 tb/tb_baggage_drop_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/baggage_drop_seq.sv
// Baggage-drop controller: averages the non-zero height sensors, derives the
// fall time t_act = sqrt(height)/2 in fixed point, and decides whether to drop.
// The average and the root are both computed iteratively, one bit per cycle.
module baggage_drop_seq #(
  parameter int N_SENSORS = 4,
  parameter int SENS_W    = 8,
  parameter int FRAC_BITS = 8,
  parameter int TLIM_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [N_SENSORS*SENS_W-1:0]   sensors,
  input  logic [TLIM_W-1:0]             t_lim,
  input  logic                          drop_en,
  output logic                          busy,
  output logic                          done,
  output logic [TLIM_W-1:0]             t_act,
  output logic                          drop_activated,
  output logic [6:0]                    seven_seg1,
  output logic [6:0]                    seven_seg2,
  output logic [6:0]                    seven_seg3,
  output logic [6:0]                    seven_seg4
);

  localparam int RAD_W    = SENS_W + 2*FRAC_BITS;
  localparam int RW       = (RAD_W + 1) / 2;
  localparam int CNT_W    = $clog2(N_SENSORS + 1);
  localparam int SUM_W    = SENS_W + $clog2(N_SENSORS);
  localparam int MAX_A    = (N_SENSORS > SENS_W) ? N_SENSORS : SENS_W;
  localparam int MAX_STEP = (MAX_A > RW) ? MAX_A : RW;
  localparam int STEP_W   = (MAX_STEP > 1) ? $clog2(MAX_STEP) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SUM, S_DIV, S_SQRT, S_CMP} state_t;

  state_t state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;

  // Operand snapshot and iteration registers (data only, no reset needed)
  logic [N_SENSORS*SENS_W-1:0] snap_q;
  logic [TLIM_W-1:0]           tlim_q;
  logic                        en_q;
  logic [SUM_W-1:0]            sum_q, sum_nxt;
  logic [CNT_W-1:0]            cnt_q, cnt_nxt;
  logic [SENS_W-1:0]           cur;
  logic [SUM_W-1:0]            rem_q, rem_nxt, div_trial;
  logic [SENS_W-1:0]           quo_q, quo_nxt, height_v;
  logic                        div_ge;
  logic [2*RW-1:0]             rad_q, rad_load;
  logic [RW+1:0]               sq_rem_q, sq_rem_sh, sq_rem_nxt, sq_trial;
  logic [RW-1:0]               root_q, root_nxt;
  logic                        sq_ge;
  logic                        sum_last, div_last, sqrt_last;
  logic [TLIM_W-1:0]           t_act_nxt;
  logic                        drop_nxt;

  // Four-digit display word {digit1..digit4}, segments {g,f,e,d,c,b,a}
  function automatic logic [27:0] disp_word(input logic drop);
    if (drop) return {7'b1011110, 7'b1010000, 7'b1011100, 7'b1110011};
    else      return {7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110};
  endfunction

  assign busy      = (state_q != S_IDLE);
  assign sum_last  = (step_q == STEP_W'(N_SENSORS - 1));
  assign div_last  = (step_q == STEP_W'(SENS_W - 1));
  assign sqrt_last = (step_q == STEP_W'(RW - 1));

  // Accumulate the current sensor if it reads non-zero
  always_comb begin
    cur     = snap_q[SENS_W-1:0];
    sum_nxt = sum_q;
    cnt_nxt = cnt_q;
    if (cur != '0) begin
      sum_nxt = sum_q + {{(SUM_W-SENS_W){1'b0}}, cur};
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  // One restoring-division step; the quotient bits shift in behind the dividend
  always_comb begin
    div_trial = (rem_q << 1) | {{(SUM_W-1){1'b0}}, quo_q[SENS_W-1]};
    div_ge    = (div_trial >= {{(SUM_W-CNT_W){1'b0}}, cnt_q});
    rem_nxt   = div_ge ? (div_trial - {{(SUM_W-CNT_W){1'b0}}, cnt_q}) : div_trial;
    quo_nxt   = (quo_q << 1) | {{(SENS_W-1){1'b0}}, div_ge};
    height_v  = (cnt_q == '0) ? '0 : quo_nxt;
    rad_load  = {{(2*RW-SENS_W){1'b0}}, height_v} << (2*FRAC_BITS);
  end

  // One digit-by-digit square-root step, two radicand bits per cycle
  always_comb begin
    sq_rem_sh  = (sq_rem_q << 2) | {{RW{1'b0}}, rad_q[2*RW-1 -: 2]};
    sq_trial   = {root_q, 2'b01};
    sq_ge      = (sq_rem_sh >= sq_trial);
    sq_rem_nxt = sq_ge ? (sq_rem_sh - sq_trial) : sq_rem_sh;
    root_nxt   = (root_q << 1) | {{(RW-1){1'b0}}, sq_ge};
  end

  // Final time and drop decision from the completed root
  always_comb begin
    t_act_nxt = {{(TLIM_W-RW+1){1'b0}}, root_q[RW-1:1]};
    drop_nxt  = en_q & (t_act_nxt <= tlim_q);
  end

  // State and step-counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Next-state logic: each stage runs a fixed number of steps
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: if (start) begin state_d = S_SUM; step_d = '0; end
      S_SUM:  if (sum_last) begin state_d = S_DIV; step_d = '0; end
              else step_d = step_q + STEP_W'(1);
      S_DIV:  if (div_last) begin state_d = S_SQRT; step_d = '0; end
              else step_d = step_q + STEP_W'(1);
      S_SQRT: if (sqrt_last) begin state_d = S_CMP; step_d = '0; end
              else step_d = step_q + STEP_W'(1);
      S_CMP:  state_d = S_IDLE;
      default: begin state_d = S_IDLE; step_d = '0; end
    endcase
  end

  // Datapath iteration: snapshot, sum, divide, root
  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE: if (start) begin
        snap_q <= sensors;
        tlim_q <= t_lim;
        en_q   <= drop_en;
        sum_q  <= '0;
        cnt_q  <= '0;
      end
      S_SUM: begin
        snap_q <= snap_q >> SENS_W;
        sum_q  <= sum_nxt;
        cnt_q  <= cnt_nxt;
        if (sum_last) begin
          rem_q <= sum_nxt >> SENS_W;
          quo_q <= sum_nxt[SENS_W-1:0];
        end
      end
      S_DIV: begin
        rem_q <= rem_nxt;
        quo_q <= quo_nxt;
        if (div_last) begin
          rad_q    <= rad_load;
          sq_rem_q <= '0;
          root_q   <= '0;
        end
      end
      S_SQRT: begin
        rad_q    <= rad_q << 2;
        sq_rem_q <= sq_rem_nxt;
        root_q   <= root_nxt;
      end
      default: ;
    endcase
  end

  // Result registers: updated only in CMP, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done           <= 1'b0;
      t_act          <= '0;
      drop_activated <= 1'b0;
      {seven_seg1, seven_seg2, seven_seg3, seven_seg4} <= disp_word(1'b0);
    end else begin
      done <= (state_q == S_CMP);
      if (state_q == S_CMP) begin
        t_act          <= t_act_nxt;
        drop_activated <= drop_nxt;
        {seven_seg1, seven_seg2, seven_seg3, seven_seg4} <= disp_word(drop_nxt);
      end
    end
  end

endmodule

// File: tb/tb_baggage_drop_seq.sv
// Self-checking bench for baggage_drop_seq with a behavioural reference model.
module tb_baggage_drop_seq;

  localparam int L = 25;

  logic        clk, rst_n, start, drop_en;
  logic [31:0] sensors;
  logic [15:0] t_lim;
  logic        busy, done, drop_activated;
  logic [15:0] t_act;
  logic [6:0]  seven_seg1, seven_seg2, seven_seg3, seven_seg4;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_t = '0, prev_t = '0;
  logic        exp_d = 1'b0, prev_d = 1'b0;

  baggage_drop_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sensors(sensors), .t_lim(t_lim),
    .drop_en(drop_en), .busy(busy), .done(done), .t_act(t_act),
    .drop_activated(drop_activated), .seven_seg1(seven_seg1),
    .seven_seg2(seven_seg2), .seven_seg3(seven_seg3), .seven_seg4(seven_seg4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] seg_exp(input logic d);
    return d ? {7'b1011110, 7'b1010000, 7'b1011100, 7'b1110011}
             : {7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110};
  endfunction

  // Reference: mean of non-zero readings, t = floor(sqrt(h * 2^16)) / 2
  task automatic model(input logic [31:0] sv, input logic [15:0] tl, input logic en,
                       output logic [15:0] t, output logic d);
    int s = 0, c = 0, h;
    longint r = 0, rr;
    for (int k = 0; k < 4; k++) begin
      int v = int'(sv[k*8 +: 8]);
      if (v != 0) begin s += v; c++; end
    end
    h = (c != 0) ? s / c : 0;
    rr = longint'(h) * 65536;
    while ((r + 1) * (r + 1) <= rr) r++;
    t = 16'(r >> 1);
    d = en && (t <= tl);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present operands and raise start at the current negedge
  task automatic launch(input logic [31:0] sv, input logic [15:0] tl, input logic en);
    prev_t  = exp_t;
    prev_d  = exp_d;
    sensors = sv;
    t_lim   = tl;
    drop_en = en;
    start   = 1'b1;
    model(sv, tl, en, exp_t, exp_d);
  endtask

  // Follow one transaction from its start edge to the done cycle
  task automatic run_body(input bit noise);
    for (int k = 0; k <= L; k++) begin
      tick();
      if (k < L) begin
        chk("busy_run", busy, 1'b1);
        chk("done_early", done, 1'b0);
        chk("hold_t", t_act, prev_t);
        chk("hold_d", drop_activated, prev_d);
      end else begin
        chk("done", done, 1'b1);
        chk("busy_end", busy, 1'b0);
        chk("t_act", t_act, exp_t);
        chk("drop", drop_activated, exp_d);
        chk("segs", {seven_seg1, seven_seg2, seven_seg3, seven_seg4}, seg_exp(exp_d));
      end
      if (k < L) begin
        start   = (noise && (k == 2 || k == 9));
        sensors = $urandom;
        t_lim   = 16'($urandom);
        drop_en = 1'($urandom);
      end
    end
  endtask

  task automatic idle_check(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_done", done, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_t", t_act, exp_t);
      chk("idle_d", drop_activated, exp_d);
      chk("idle_segs", {seven_seg1, seven_seg2, seven_seg3, seven_seg4}, seg_exp(exp_d));
    end
  endtask

  initial begin
    logic [31:0] sv;
    logic [15:0] tl, tm;
    logic        en, dm;
    rst_n = 1'b0; start = 1'b0; sensors = '0; t_lim = '0; drop_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_t", t_act, 16'h0000);
    chk("rst_d", drop_activated, 1'b0);
    chk("rst_segs", {seven_seg1, seven_seg2, seven_seg3, seven_seg4},
        {7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110});
    rst_n = 1'b1;
    idle_check(2);

    // Directed cases with literal expectations
    launch({8'd36, 8'd36, 8'd36, 8'd36}, 16'h0300, 1'b1); run_body(0);
    chk("t1_t", t_act, 16'h0300); chk("t1_d", drop_activated, 1'b1);
    chk("t1_seg", {seven_seg1, seven_seg2, seven_seg3, seven_seg4},
        {7'b1011110, 7'b1010000, 7'b1011100, 7'b1110011});
    idle_check(2);
    launch({8'd36, 8'd36, 8'd36, 8'd36}, 16'h02FF, 1'b1); run_body(0);
    chk("t2_d", drop_activated, 1'b0);
    chk("t2_seg", {seven_seg1, seven_seg2, seven_seg3, seven_seg4},
        {7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110});
    idle_check(1);
    launch({8'd36, 8'd36, 8'd36, 8'd36}, 16'hFFFF, 1'b0); run_body(0);
    chk("t2_en0", drop_activated, 1'b0);
    idle_check(1);
    launch({8'd16, 8'd0, 8'd16, 8'd0}, 16'h0000, 1'b1); run_body(0);
    chk("t3a_t", t_act, 16'h0200);
    idle_check(1);
    launch({8'd2, 8'd2, 8'd2, 8'd2}, 16'h00B5, 1'b1); run_body(0);
    chk("t3b_t", t_act, 16'h00B5); chk("t3b_d", drop_activated, 1'b1);
    idle_check(1);
    launch(32'h0, 16'h0000, 1'b1); run_body(0);
    chk("t4a_t", t_act, 16'h0000); chk("t4a_d", drop_activated, 1'b1);
    idle_check(1);
    launch(32'hFFFF_FFFF, 16'h07FA, 1'b1); run_body(0);
    chk("t4b_t", t_act, 16'h07FB); chk("t4b_d", drop_activated, 1'b0);
    idle_check(1);

    // Starts while busy are ignored; then back-to-back start with done
    launch({8'd100, 8'd0, 8'd50, 8'd9}, 16'h0400, 1'b1); run_body(1);
    idle_check(L + 2);
    launch({8'd1, 8'd2, 8'd3, 8'd4}, 16'h0100, 1'b1); run_body(0);
    launch({8'd200, 8'd200, 8'd0, 8'd0}, 16'h0800, 1'b1); run_body(0);
    idle_check(2);

    // Asynchronous reset mid-run
    launch({8'd36, 8'd36, 8'd36, 8'd36}, 16'h0300, 1'b1);
    for (int k = 0; k < 12; k++) begin
      tick();
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_t", t_act, 16'h0000);
    chk("mid_rst_d", drop_activated, 1'b0);
    chk("mid_rst_seg", {seven_seg1, seven_seg2, seven_seg3, seven_seg4},
        {7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110});
    exp_t = '0; exp_d = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_check(2);
    launch({8'd49, 8'd49, 8'd49, 8'd49}, 16'h0400, 1'b1); run_body(0);
    chk("after_rst_t", t_act, 16'h0380);
    idle_check(1);

    // Randomised transactions, limits often placed right at the boundary
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 4; k++)
        sv[k*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      en = ($urandom_range(0, 3) != 0);
      model(sv, 16'h0, en, tm, dm);
      case ($urandom_range(0, 2))
        0: tl = tm;
        1: tl = (tm == 0) ? 16'h0 : tm - 16'd1;
        default: tl = 16'($urandom);
      endcase
      launch(sv, tl, en);
      run_body(n % 7 == 3);
      if (n % 3 != 0) idle_check($urandom_range(1, 3));
    end
    idle_check(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
